// File: rtl/spi_avalon_transmitter.sv
// Avalon-MM slave with a TX FIFO feeding an SPI mode-0 master (MSB first, active-low CS).
// Optional macro SPI_TX_IRQ_EN adds a registered "idle and empty" interrupt.
module spi_avalon_transmitter #(
    parameter int FIFO_DEPTH = 16,
    parameter int CLK_DIV    = 4,
    parameter int CS_GAP     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  io_Avalon_address,
    input  logic        io_Avalon_read,
    input  logic        io_Avalon_write,
    input  logic [31:0] io_Avalon_writedata,
    output logic [31:0] io_Avalon_readdata,
    output logic        io_SCLK,
    output logic        io_MOSI,
    output logic        io_CS,
    output logic        io_irq
);

    // State table:
    //   S_IDLE  | CS high, waiting for a queued byte
    //   S_SETUP | CS low, bit7 presented, SCLK low for one half-period
    //   S_HIGH  | SCLK high, receiver samples MOSI
    //   S_LOW   | SCLK low, next bit presented
    //   S_HOLD  | last bit done, CS still low for one half-period
    //   S_GAP   | CS high for CS_GAP half-periods before the next frame
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW, S_HOLD, S_GAP} state_t;

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = $clog2(FIFO_DEPTH + 1);
    localparam int GAP_CYC = CS_GAP * CLK_DIV;
    localparam int TW      = $clog2(GAP_CYC + 1);
    localparam logic [TW-1:0] DIV_LOAD = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYC - 1);

    state_t          state_q, state_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [31:0]     readdata_q, readdata_d;
    logic            sclk_q, sclk_d, mosi_q, mosi_d, cs_q, cs_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic            irq_en_q, irq_en_d;

    logic wr_data, wr_ctrl, push, pop, empty, full, tmr_done, active;
    logic [31:0] status_w, control_w;
    logic unused_wdata;

    assign unused_wdata = ^io_Avalon_writedata[31:8];

    assign wr_data  = io_Avalon_write && (io_Avalon_address == 2'd0);
    assign wr_ctrl  = io_Avalon_write && (io_Avalon_address == 2'd2);
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign tmr_done = (tmr_q == '0);

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_done ? tmr_q : tmr_q - 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    bit_d   = '0;
                    tmr_d   = DIV_LOAD;
                    state_d = S_SETUP;
                end
            end
            S_SETUP, S_LOW: begin
                if (tmr_done) begin
                    tmr_d   = DIV_LOAD;
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (tmr_done) begin
                    tmr_d = DIV_LOAD;
                    if (bit_q == 3'd7) begin
                        // Back-to-back bytes stay in the same CS-low frame.
                        if (!empty) begin
                            pop     = 1'b1;
                            shift_d = mem_q[rd_ptr_q];
                            bit_d   = '0;
                            state_d = S_SETUP;
                        end else begin
                            state_d = S_HOLD;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = {shift_q[6:0], 1'b0};
                        state_d = S_LOW;
                    end
                end
            end
            S_HOLD: begin
                if (tmr_done) begin
                    tmr_d   = GAP_LOAD;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (tmr_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        push     = wr_data && (!full || pop);
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q || (wr_data && full && !pop);
        if (wr_ctrl && io_Avalon_writedata[1]) ovf_d = 1'b0;
        irq_en_d = irq_en_q;
        if (wr_ctrl) irq_en_d = io_Avalon_writedata[0];
    end

    // Outputs are registered from next-state values so they line up with state_q.
    always_comb begin
        active = (state_d == S_SETUP) || (state_d == S_HIGH) || (state_d == S_LOW);
        sclk_d = (state_d == S_HIGH);
        cs_d   = !(active || (state_d == S_HOLD));
        mosi_d = active ? shift_d[7] : 1'b0;
    end

    always_comb begin
        status_w   = {16'b0, 8'(count_q), 4'b0, ovf_q, empty, full, state_q != S_IDLE};
`ifdef SPI_TX_IRQ_EN
        control_w  = {31'b0, irq_en_q};
`else
        control_w  = 32'b0;
`endif
        readdata_d = readdata_q;
        if (io_Avalon_read) begin
            case (io_Avalon_address)
                2'd1:    readdata_d = status_w;
                2'd2:    readdata_d = control_w;
                default: readdata_d = 32'b0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            tmr_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            readdata_q <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            readdata_q <= readdata_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_q       <= cs_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= io_Avalon_writedata[7:0];
    end

`ifdef SPI_TX_IRQ_EN
    logic irq_q, irq_d;
    assign irq_d = irq_en_d && (count_d == '0) && (state_d == S_IDLE);
    always_ff @(posedge clock) begin
        if (reset) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end
    assign io_irq = irq_q;
`else
    assign irq_en_q = 1'b0;
    assign io_irq   = 1'b0;
    logic unused_irq;
    assign unused_irq = irq_en_d;
`endif

    assign io_Avalon_readdata = readdata_q;
    assign io_SCLK            = sclk_q;
    assign io_MOSI            = mosi_q;
    assign io_CS              = cs_q;

endmodule

// File: tb/tb_spi_avalon_transmitter.sv
// Directed bench for spi_avalon_transmitter: an SPI receiver model captures bytes on SCLK rises.
module tb_spi_avalon_transmitter;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  io_Avalon_address;
    logic        io_Avalon_read;
    logic        io_Avalon_write;
    logic [31:0] io_Avalon_writedata;
    logic [31:0] io_Avalon_readdata;
    logic        io_SCLK, io_MOSI, io_CS, io_irq;

    int checks = 0;
    int errors = 0;

    spi_avalon_transmitter #(.FIFO_DEPTH(16), .CLK_DIV(4), .CS_GAP(2)) dut (
        .clock               (clock),
        .reset               (reset),
        .io_Avalon_address   (io_Avalon_address),
        .io_Avalon_read      (io_Avalon_read),
        .io_Avalon_write     (io_Avalon_write),
        .io_Avalon_writedata (io_Avalon_writedata),
        .io_Avalon_readdata  (io_Avalon_readdata),
        .io_SCLK             (io_SCLK),
        .io_MOSI             (io_MOSI),
        .io_CS               (io_CS),
        .io_irq              (io_irq)
    );

    always #5 clock = ~clock;

    // Receiver model and event recorders.
    logic [7:0] rx_q[$];
    logic [7:0] rx_sh = 8'h00;
    int   rx_bits = 0;
    int   sclk_rises = 0;
    int   cs_falls = 0;
    int   mosi_viol = 0;
    time  last_fall_t = 0;
    time  cs_rise_t = 0;
    time  irq_rise_t = 0;

    always @(posedge io_SCLK) begin
        if (!io_CS) begin
            sclk_rises++;
            rx_sh = {rx_sh[6:0], io_MOSI};
            rx_bits++;
            if (rx_bits == 8) begin
                rx_q.push_back(rx_sh);
                rx_bits = 0;
            end
        end
    end
    always @(negedge io_SCLK) last_fall_t = $time;
    always @(negedge io_CS) cs_falls++;
    always @(posedge io_CS) begin
        cs_rise_t = $time;
        rx_bits   = 0;
    end
    always @(posedge io_irq) irq_rise_t = $time;
    always @(io_MOSI) if (io_SCLK) mosi_viol++;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic av_write(input logic [1:0] addr, input logic [31:0] data);
        io_Avalon_address   = addr;
        io_Avalon_writedata = data;
        io_Avalon_write     = 1'b1;
        tick();
        io_Avalon_write     = 1'b0;
    endtask

    task automatic av_read(input logic [1:0] addr, output logic [31:0] data);
        io_Avalon_address = addr;
        io_Avalon_read    = 1'b1;
        tick();
        io_Avalon_read    = 1'b0;
        data = io_Avalon_readdata;
    endtask

    task automatic wait_idle(input int budget, output logic timed_out);
        logic [31:0] st;
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            av_read(2'd1, st);
            if (st[0] == 1'b0 && st[2] == 1'b1 && io_CS == 1'b1) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    logic [31:0] rd;
    logic        to;
    int          base_rx, base_rises, base_falls;

    initial begin
        reset = 1'b1;
        io_Avalon_address = 2'd0;
        io_Avalon_read = 1'b0;
        io_Avalon_write = 1'b0;
        io_Avalon_writedata = 32'h0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        check("rst_cs", {31'b0, io_CS}, 32'd1);
        check("rst_sclk", {31'b0, io_SCLK}, 32'd0);
        check("rst_mosi", {31'b0, io_MOSI}, 32'd0);
        check("rst_irq", {31'b0, io_irq}, 32'd0);
        check("rst_readdata", io_Avalon_readdata, 32'h0);
        av_read(2'd1, rd);
        check("rst_status", rd, 32'h0000_0004);
        av_read(2'd3, rd);
        check("addr3_read", rd, 32'h0);

        // Single byte 0x7A: CS at N+2, first SCLK rise at N+2+CLK_DIV
        base_rx = rx_q.size();
        base_falls = cs_falls;
        av_write(2'd0, 32'h0000_007A);
        check("cs_n1_high", {31'b0, io_CS}, 32'd1);
        tick();
        check("cs_n2_low", {31'b0, io_CS}, 32'd0);
        repeat (3) tick();
        check("sclk_setup_low", {31'b0, io_SCLK}, 32'd0);
        tick();
        check("sclk_first_rise", {31'b0, io_SCLK}, 32'd1);
        wait_idle(400, to);
        check("t1_timeout", {31'b0, to}, 32'd0);
        check("t1_rx_count", rx_q.size() - base_rx, 32'd1);
        if (rx_q.size() > base_rx) check("t1_rx_byte", {24'b0, rx_q[base_rx]}, 32'd122);
        check("t1_hold_time", 32'(cs_rise_t - last_fall_t), 32'd40);
        check("t1_frames", cs_falls - base_falls, 32'd1);

        // Two bytes back-to-back form one 16-pulse frame
        base_rx = rx_q.size();
        base_rises = sclk_rises;
        base_falls = cs_falls;
        av_write(2'd0, 32'h0000_000C);
        av_write(2'd0, 32'h0000_0040);
        wait_idle(600, to);
        check("t2_timeout", {31'b0, to}, 32'd0);
        check("t2_frames", cs_falls - base_falls, 32'd1);
        check("t2_pulses", sclk_rises - base_rises, 32'd16);
        check("t2_rx_count", rx_q.size() - base_rx, 32'd2);
        if (rx_q.size() >= base_rx + 2) begin
            check("t2_byte0", {24'b0, rx_q[base_rx]}, 32'd12);
            check("t2_byte1", {24'b0, rx_q[base_rx + 1]}, 32'd64);
        end

        // Overflow: one byte in flight, then 17 pushes into a 16-deep FIFO
        base_rx = rx_q.size();
        base_falls = cs_falls;
        av_write(2'd0, 32'h0000_0055);
        for (int i = 1; i <= 16; i++) av_write(2'd0, 32'(i));
        av_write(2'd0, 32'h0000_00EE);
        av_read(2'd1, rd);
        check("t3_status_ovf", rd, 32'h0000_100B);
        av_write(2'd2, 32'h0000_0002);
        av_read(2'd1, rd);
        check("t3_status_clr", rd, 32'h0000_1003);
        av_read(2'd0, rd);
        check("t3_data_read", rd, 32'h0);
        wait_idle(3000, to);
        check("t3_timeout", {31'b0, to}, 32'd0);
        check("t3_rx_count", rx_q.size() - base_rx, 32'd17);
        check("t3_frames", cs_falls - base_falls, 32'd1);
        if (rx_q.size() >= base_rx + 17) begin
            check("t3_first", {24'b0, rx_q[base_rx]}, 32'h55);
            check("t3_mid", {24'b0, rx_q[base_rx + 8]}, 32'd8);
            check("t3_last", {24'b0, rx_q[base_rx + 16]}, 32'd16);
        end

        // Reset mid-frame with 5 bytes queued
        base_rises = sclk_rises;
        for (int i = 0; i < 6; i++) av_write(2'd0, 32'h11 + 32'(i));
        to = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (sclk_rises - base_rises >= 4) begin
                to = 1'b0;
                break;
            end
            tick();
        end
        check("t4_reach_bit3", {31'b0, to}, 32'd0);
        base_rx = rx_q.size();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t4_cs", {31'b0, io_CS}, 32'd1);
        check("t4_sclk", {31'b0, io_SCLK}, 32'd0);
        av_read(2'd1, rd);
        check("t4_status", rd, 32'h0000_0004);
        base_rises = sclk_rises;
        repeat (300) tick();
        check("t4_no_pulses", sclk_rises - base_rises, 32'd0);
        check("t4_no_bytes", rx_q.size() - base_rx, 32'd0);

        // CONTROL and interrupt
        av_write(2'd2, 32'h0000_0001);
`ifdef SPI_TX_IRQ_EN
        check("irq_idle", {31'b0, io_irq}, 32'd1);
        av_read(2'd2, rd);
        check("ctrl_read", rd, 32'h1);
        av_write(2'd0, 32'h0000_003C);
        check("irq_drop", {31'b0, io_irq}, 32'd0);
        to = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (io_irq) begin
                to = 1'b0;
                break;
            end
            tick();
        end
        check("irq_return", {31'b0, to}, 32'd0);
        check("irq_after_gap", 32'(irq_rise_t - cs_rise_t), 32'd80);
`else
        av_read(2'd2, rd);
        check("ctrl_read", rd, 32'h0);
        av_write(2'd0, 32'h0000_003C);
        check("irq_tied", {31'b0, io_irq}, 32'd0);
        wait_idle(400, to);
        check("irq_tied_idle", {31'b0, io_irq}, 32'd0);
`endif
        check("mosi_stable", mosi_viol, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
